// File: rtl/riscv_hwloop_cfg_sequencer.sv
// Hardware-loop configuration sequencer.
// Holds the start/end/counter registers for both hardware loops, accepts
// configuration commands from ID, walks a SETUP through the single write
// port one field per cycle, and applies controller counter decrements.
module riscv_hwloop_cfg_sequencer #(
   parameter int N_REGS = 2,
   parameter int CNT_W  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [1:0]       cmd_op_i,
   input  logic             cmd_idx_i,
   input  logic [31:0]      cmd_start_i,
   input  logic [31:0]      cmd_end_i,
   input  logic [CNT_W-1:0] cmd_cnt_i,
   input  logic [1:0]       hwlp_dec_cnt_i,
   input  logic             flush_i,
   output logic [31:0]      hwlp_start_addr_0_o,
   output logic [31:0]      hwlp_end_addr_0_o,
   output logic [CNT_W-1:0] hwlp_counter_0_o,
   output logic [31:0]      hwlp_start_addr_1_o,
   output logic [31:0]      hwlp_end_addr_1_o,
   output logic [CNT_W-1:0] hwlp_counter_1_o,
   output logic             busy_o,
   output logic             err_o
);

   localparam logic [1:0] OP_START = 2'b00;
   localparam logic [1:0] OP_END   = 2'b01;
   localparam logic [1:0] OP_COUNT = 2'b10;
   localparam logic [1:0] OP_SETUP = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      WR_END = 2'b01,
      WR_CNT = 2'b10
   } state_t;

   state_t           state_q;
   logic [31:0]      start_q [N_REGS];
   logic [31:0]      end_q   [N_REGS];
   logic [CNT_W-1:0] cnt_q   [N_REGS];
   logic             hold_idx_q;
   logic [31:0]      hold_end_q;
   logic [CNT_W-1:0] hold_cnt_q;
   logic             err_q;
   logic             accept;
   logic             setup_bad;

   assign cmd_ready_o = (state_q == IDLE) & ~flush_i;
   assign accept      = cmd_valid_i & cmd_ready_o;
   assign setup_bad   = (cmd_end_i <= cmd_start_i) || (cmd_cnt_i == '0);
   assign busy_o      = (state_q != IDLE);
   assign err_o       = err_q;

   assign hwlp_start_addr_0_o = start_q[0];
   assign hwlp_end_addr_0_o   = end_q[0];
   assign hwlp_counter_0_o    = cnt_q[0];
   assign hwlp_start_addr_1_o = start_q[1];
   assign hwlp_end_addr_1_o   = end_q[1];
   assign hwlp_counter_1_o    = cnt_q[1];

   // Register update: flush first, then saturating decrements, then any
   // command/sequencer write, which lands last so it overrides a decrement
   // of the same counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         hold_idx_q <= 1'b0;
         hold_end_q <= '0;
         hold_cnt_q <= '0;
         err_q      <= 1'b0;
         for (int i = 0; i < N_REGS; i++) begin
            start_q[i] <= '0;
            end_q[i]   <= '0;
            cnt_q[i]   <= '0;
         end
      end else if (flush_i) begin
         state_q <= IDLE;
         err_q   <= 1'b0;
         for (int i = 0; i < N_REGS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         err_q <= 1'b0;
         for (int i = 0; i < N_REGS; i++) begin
            if (hwlp_dec_cnt_i[i] && (cnt_q[i] != '0)) begin
               cnt_q[i] <= cnt_q[i] - CNT_W'(1);
            end
         end
         case (state_q)
            IDLE: begin
               if (accept) begin
                  case (cmd_op_i)
                     OP_START: start_q[cmd_idx_i] <= cmd_start_i;
                     OP_END:   end_q[cmd_idx_i]   <= cmd_end_i;
                     OP_COUNT: cnt_q[cmd_idx_i]   <= cmd_cnt_i;
                     OP_SETUP: begin
                        if (setup_bad) begin
                           err_q <= 1'b1;
                        end else begin
                           start_q[cmd_idx_i] <= cmd_start_i;
                           hold_idx_q         <= cmd_idx_i;
                           hold_end_q         <= cmd_end_i;
                           hold_cnt_q         <= cmd_cnt_i;
                           state_q            <= WR_END;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            WR_END: begin
               end_q[hold_idx_q] <= hold_end_q;
               state_q           <= WR_CNT;
            end
            WR_CNT: begin
               cnt_q[hold_idx_q] <= hold_cnt_q;
               state_q           <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_hwloop_cfg_sequencer.sv
// Directed bench for riscv_hwloop_cfg_sequencer.
module tb_riscv_hwloop_cfg_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic [1:0]  cmd_op_i;
   logic        cmd_idx_i;
   logic [31:0] cmd_start_i;
   logic [31:0] cmd_end_i;
   logic [31:0] cmd_cnt_i;
   logic [1:0]  hwlp_dec_cnt_i;
   logic        flush_i;
   logic [31:0] start_0, end_0, counter_0, start_1, end_1, counter_1;
   logic        busy_o;
   logic        err_o;

   int vectors = 0;
   int miscompares = 0;

   riscv_hwloop_cfg_sequencer #(.N_REGS(2), .CNT_W(32)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .cmd_valid_i         (cmd_valid_i),
      .cmd_ready_o         (cmd_ready_o),
      .cmd_op_i            (cmd_op_i),
      .cmd_idx_i           (cmd_idx_i),
      .cmd_start_i         (cmd_start_i),
      .cmd_end_i           (cmd_end_i),
      .cmd_cnt_i           (cmd_cnt_i),
      .hwlp_dec_cnt_i      (hwlp_dec_cnt_i),
      .flush_i             (flush_i),
      .hwlp_start_addr_0_o (start_0),
      .hwlp_end_addr_0_o   (end_0),
      .hwlp_counter_0_o    (counter_0),
      .hwlp_start_addr_1_o (start_1),
      .hwlp_end_addr_1_o   (end_1),
      .hwlp_counter_1_o    (counter_1),
      .busy_o              (busy_o),
      .err_o               (err_o)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cmd_valid_i    = 1'b0;
      cmd_op_i       = 2'b00;
      cmd_idx_i      = 1'b0;
      cmd_start_i    = '0;
      cmd_end_i      = '0;
      cmd_cnt_i      = '0;
      hwlp_dec_cnt_i = 2'b00;
      flush_i        = 1'b0;
   endtask

   task automatic issue(input logic [1:0] op, input logic idx,
                        input logic [31:0] s, input logic [31:0] e, input logic [31:0] c);
      cmd_valid_i = 1'b1;
      cmd_op_i    = op;
      cmd_idx_i   = idx;
      cmd_start_i = s;
      cmd_end_i   = e;
      cmd_cnt_i   = c;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      #12;
      vectors++; if (start_0 !== 32'h0 || end_0 !== 32'h0 || counter_0 !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_loop0: got %h/%h/%h expected 0/0/0", start_0, end_0, counter_0); end
      vectors++; if (start_1 !== 32'h0 || end_1 !== 32'h0 || counter_1 !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_loop1: got %h/%h/%h expected 0/0/0", start_1, end_1, counter_1); end
      vectors++; if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || err_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ctrl: got rdy=%b busy=%b err=%b expected 1/0/0", cmd_ready_o, busy_o, err_o); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_setup();
      issue(2'b11, 1'b0, 32'h100, 32'h120, 32'd5);
      step();
      idle_inputs();
      vectors++; if (start_0 !== 32'h100) begin miscompares++; $display("[TB] FAIL setup_start0: got %h expected %h", start_0, 32'h100); end
      vectors++; if (end_0 !== 32'h0 || counter_0 !== 32'h0) begin miscompares++; $display("[TB] FAIL setup_n1_pending: got end=%h cnt=%h expected 0/0", end_0, counter_0); end
      vectors++; if (busy_o !== 1'b1 || cmd_ready_o !== 1'b0) begin miscompares++; $display("[TB] FAIL setup_n1_ctrl: got busy=%b rdy=%b expected 1/0", busy_o, cmd_ready_o); end
      step();
      vectors++; if (end_0 !== 32'h120 || counter_0 !== 32'h0) begin miscompares++; $display("[TB] FAIL setup_end0: got end=%h cnt=%h expected 120/0", end_0, counter_0); end
      vectors++; if (busy_o !== 1'b1 || cmd_ready_o !== 1'b0) begin miscompares++; $display("[TB] FAIL setup_n2_ctrl: got busy=%b rdy=%b expected 1/0", busy_o, cmd_ready_o); end
      step();
      vectors++; if (counter_0 !== 32'd5) begin miscompares++; $display("[TB] FAIL setup_cnt0: got %0d expected 5", counter_0); end
      vectors++; if (busy_o !== 1'b0 || cmd_ready_o !== 1'b1 || err_o !== 1'b0) begin miscompares++; $display("[TB] FAIL setup_n3_ctrl: got busy=%b rdy=%b err=%b expected 0/1/0", busy_o, cmd_ready_o, err_o); end
   endtask

   task automatic test_setup_reject();
      issue(2'b11, 1'b1, 32'h200, 32'h200, 32'd3);
      step();
      idle_inputs();
      vectors++; if (err_o !== 1'b1 || busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reject_err: got err=%b busy=%b expected 1/0", err_o, busy_o); end
      vectors++; if (start_1 !== 32'h0 || end_1 !== 32'h0 || counter_1 !== 32'h0) begin miscompares++; $display("[TB] FAIL reject_loop1: got %h/%h/%h expected 0/0/0", start_1, end_1, counter_1); end
      step();
      vectors++; if (err_o !== 1'b0 || busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reject_err_clear: got err=%b busy=%b expected 0/0", err_o, busy_o); end
      issue(2'b11, 1'b1, 32'h200, 32'h300, 32'd0);
      step();
      idle_inputs();
      vectors++; if (err_o !== 1'b1 || busy_o !== 1'b0 || start_1 !== 32'h0) begin miscompares++; $display("[TB] FAIL reject_zero_cnt: got err=%b busy=%b start1=%h expected 1/0/0", err_o, busy_o, start_1); end
      step();
   endtask

   task automatic test_back_to_back();
      issue(2'b00, 1'b1, 32'h600, 32'h0, 32'h0);
      step();
      vectors++; if (start_1 !== 32'h600 || cmd_ready_o !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_start1: got %h rdy=%b expected 600/1", start_1, cmd_ready_o); end
      issue(2'b01, 1'b1, 32'h0, 32'h700, 32'h0);
      step();
      vectors++; if (end_1 !== 32'h700 || start_1 !== 32'h600) begin miscompares++; $display("[TB] FAIL b2b_end1: got end=%h start=%h expected 700/600", end_1, start_1); end
      issue(2'b10, 1'b1, 32'h0, 32'h0, 32'd6);
      step();
      idle_inputs();
      vectors++; if (counter_1 !== 32'd6 || busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_cnt1: got %0d busy=%b expected 6/0", counter_1, busy_o); end
   endtask

   task automatic test_decrement();
      logic [31:0] exp_seq [3];
      exp_seq[0] = 32'd1;
      exp_seq[1] = 32'd0;
      exp_seq[2] = 32'd0;
      issue(2'b10, 1'b0, 32'h0, 32'h0, 32'd2);
      step();
      idle_inputs();
      vectors++; if (counter_0 !== 32'd2) begin miscompares++; $display("[TB] FAIL dec_preload: got %0d expected 2", counter_0); end
      hwlp_dec_cnt_i = 2'b01;
      for (int k = 0; k < 3; k++) begin
         step();
         vectors++; if (counter_0 !== exp_seq[k]) begin miscompares++; $display("[TB] FAIL dec_step%0d: got %0d expected %0d", k, counter_0, exp_seq[k]); end
      end
      hwlp_dec_cnt_i = 2'b00;
      vectors++; if (counter_1 !== 32'd6) begin miscompares++; $display("[TB] FAIL dec_other_loop: got %0d expected 6", counter_1); end
   endtask

   task automatic test_collision();
      issue(2'b10, 1'b0, 32'h0, 32'h0, 32'd4);
      step();
      issue(2'b10, 1'b1, 32'h0, 32'h0, 32'd9);
      step();
      vectors++; if (counter_0 !== 32'd4 || counter_1 !== 32'd9) begin miscompares++; $display("[TB] FAIL coll_preload: got %0d/%0d expected 4/9", counter_0, counter_1); end
      issue(2'b10, 1'b0, 32'h0, 32'h0, 32'd7);
      hwlp_dec_cnt_i = 2'b11;
      step();
      idle_inputs();
      vectors++; if (counter_0 !== 32'd7) begin miscompares++; $display("[TB] FAIL coll_write_wins: got %0d expected 7", counter_0); end
      vectors++; if (counter_1 !== 32'd8) begin miscompares++; $display("[TB] FAIL coll_other_dec: got %0d expected 8", counter_1); end
   endtask

   task automatic test_dec_during_wr_end();
      issue(2'b11, 1'b1, 32'h800, 32'h880, 32'd20);
      step();
      idle_inputs();
      hwlp_dec_cnt_i = 2'b10;
      step();
      hwlp_dec_cnt_i = 2'b00;
      vectors++; if (counter_1 !== 32'd7 || end_1 !== 32'h880) begin miscompares++; $display("[TB] FAIL wrend_dec: got cnt=%0d end=%h expected 7/880", counter_1, end_1); end
      step();
      vectors++; if (counter_1 !== 32'd20 || busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL wrend_final: got cnt=%0d busy=%b expected 20/0", counter_1, busy_o); end
   endtask

   task automatic test_flush();
      issue(2'b01, 1'b1, 32'h0, 32'h50, 32'h0);
      step();
      issue(2'b11, 1'b1, 32'h300, 32'h340, 32'd2);
      step();
      vectors++; if (start_1 !== 32'h300 || busy_o !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_pre: got start1=%h busy=%b expected 300/1", start_1, busy_o); end
      issue(2'b00, 1'b0, 32'hDEAD, 32'h0, 32'h0);
      flush_i = 1'b1;
      #1;
      vectors++; if (cmd_ready_o !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_ready: got %b expected 0", cmd_ready_o); end
      step();
      idle_inputs();
      vectors++; if (busy_o !== 1'b0 || err_o !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_ctrl: got busy=%b err=%b expected 0/0", busy_o, err_o); end
      vectors++; if (counter_0 !== 32'd0 || counter_1 !== 32'd0) begin miscompares++; $display("[TB] FAIL flush_counters: got %0d/%0d expected 0/0", counter_0, counter_1); end
      vectors++; if (start_1 !== 32'h300 || end_1 !== 32'h50 || start_0 !== 32'h100) begin miscompares++; $display("[TB] FAIL flush_addr: got s1=%h e1=%h s0=%h expected 300/50/100", start_1, end_1, start_0); end
      step();
      vectors++; if (end_1 !== 32'h50 || counter_1 !== 32'd0 || cmd_ready_o !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_after: got e1=%h c1=%0d rdy=%b expected 50/0/1", end_1, counter_1, cmd_ready_o); end
   endtask

   task automatic test_reset_mid_setup();
      issue(2'b11, 1'b0, 32'h400, 32'h500, 32'd3);
      step();
      idle_inputs();
      #2;
      rst_n = 1'b0;
      #1;
      vectors++; if (start_0 !== 32'h0 || end_0 !== 32'h0 || counter_0 !== 32'h0 || start_1 !== 32'h0 || end_1 !== 32'h0 || counter_1 !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_mid_regs: got %h %h %h %h %h %h expected all 0", start_0, end_0, counter_0, start_1, end_1, counter_1); end
      vectors++; if (busy_o !== 1'b0 || err_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_ctrl: got busy=%b err=%b expected 0/0", busy_o, err_o); end
      #10;
      rst_n = 1'b1;
      step();
      vectors++; if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || end_0 !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_mid_release: got rdy=%b busy=%b end0=%h expected 1/0/0", cmd_ready_o, busy_o, end_0); end
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_setup();
      test_setup_reject();
      test_back_to_back();
      test_decrement();
      test_collision();
      test_dec_during_wr_end();
      test_flush();
      test_reset_mid_setup();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/riscv_hwloop_cfg_sequencer.md
Name: riscv_hwloop_cfg_sequencer

Overview:
- Owns the two hardware-loop register sets (start, end, counter for loops 0 and 1) that feed the hwloop controller.
- Accepts loop-configuration commands from the ID stage over a valid/ready handshake.
- Sequences multi-field setups through a single write port, one field per cycle.
- Applies counter decrements requested by the controller, and validates setups.

Parameters:
- N_REGS, 2, number of loop register sets; fixed at 2, other values unsupported.
- CNT_W, 32, counter width in bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  sequencer accepts a command this cycle.
- cmd_op_i  in  2  00 START, 01 END, 10 COUNT, 11 SETUP (start+end+count).
- cmd_idx_i  in  1  target loop (0/1).
- cmd_start_i  in  32  start address operand.
- cmd_end_i  in  32  end address operand.
- cmd_cnt_i  in  CNT_W  count operand.
- hwlp_dec_cnt_i  in  2  per-loop decrement request from the controller.
- flush_i  in  1  synchronous abort: clears both counters, returns FSM to IDLE.
- hwlp_start_addr_0_o / hwlp_end_addr_0_o / hwlp_counter_0_o  out  32/32/CNT_W  loop 0 registers.
- hwlp_start_addr_1_o / hwlp_end_addr_1_o / hwlp_counter_1_o  out  32/32/CNT_W  loop 1 registers.
- busy_o  out  1  multi-cycle SETUP in progress.
- err_o  out  1  one-cycle pulse: SETUP rejected.

Behaviour:
- Reset (async, rst_n=0):
  - All six loop registers = 0; FSM = IDLE.
  - cmd_ready_o=1, busy_o=0, err_o=0.
  - Reset during a SETUP abandons it; fields not yet written stay 0.
- FSM states: IDLE, WR_END, WR_CNT.
  - cmd_ready_o = (state==IDLE) & ~flush_i; busy_o = (state!=IDLE).
  - Handshake: a command is accepted on an edge where cmd_valid_i & cmd_ready_o.
  - Operands are captured into holding regs at acceptance; cmd_* may change afterwards.
- Single-field ops (START, END, COUNT) are accepted in IDLE.
  - The addressed field is written at the accept edge and is visible on outputs the next cycle.
  - FSM stays in IDLE, so back-to-back single ops run at one per cycle.
- SETUP accepted at edge N:
  - If cmd_end_i <= cmd_start_i (unsigned) or cmd_cnt_i==0: nothing is written, err_o=1 in cycle N+1 only, FSM stays IDLE.
  - Otherwise: start is written at edge N and FSM goes to WR_END.
  - End is written at edge N+1 and FSM goes to WR_CNT.
  - Count is written at edge N+2 and FSM returns to IDLE.
  - cmd_ready_o is 0 in cycles N+1 and N+2 and returns to 1 in cycle N+3.
- Decrement:
  - On each edge, a loop counter with hwlp_dec_cnt_i[i]=1 becomes counter-1.
  - The counter saturates at 0 (no wrap to all-ones).
  - Both loops may decrement in the same cycle.
- Collisions:
  - A COUNT or WR_CNT write to loop i in the same cycle as hwlp_dec_cnt_i[i]: the write wins, the decrement is dropped.
  - A decrement of the non-targeted loop proceeds normally.
  - A decrement during WR_END of the loop under setup applies to the old counter value.
- flush_i (highest priority after reset):
  - Both counters are cleared to 0; start/end registers are retained.
  - FSM goes to IDLE and any in-progress SETUP is abandoned with no err_o.
  - No command is accepted in the flush cycle.
- err_o is 0 in every cycle except the single cycle after a rejected SETUP.

Test Plan:
- Reset, then SETUP idx0 start=0x100 end=0x120 cnt=5.
  - Required: start_0=0x100 at N+1, end_0=0x120 at N+2, counter_0=5 at N+3.
  - Required: busy_o high in N+1..N+2; cmd_ready_o high again at N+3.
- SETUP idx1 start=0x200 end=0x200 cnt=3.
  - Required: err_o=1 for exactly one cycle; loop 1 registers unchanged; busy_o stays 0.
- counter_0=2, then hwlp_dec_cnt_i=01 held for 3 cycles.
  - Required: counter_0 steps 2,1,0,0 (saturates); counter_1 unaffected.
- COUNT idx0 cnt=7 issued in the same cycle as hwlp_dec_cnt_i[0]=1 (counter_0=4).
  - Required: counter_0=7 next cycle, decrement dropped.
  - Same cycle with hwlp_dec_cnt_i[1]=1 and counter_1=9: required counter_1=8.
- flush_i asserted in WR_END of a SETUP to idx1 (start=0x300 already written).
  - Required: next cycle FSM IDLE, both counters 0, start_1=0x300, end_1 unchanged, err_o=0.
- rst_n dropped asynchronously mid-SETUP.
  - Required: all outputs 0 immediately and cmd_ready_o=1 after release.
